// File: rtl/slave_mem_port.sv
// Single-port word memory behind a fixed-latency request/complete handshake.
// Optional SLAVE_MEM_ERR_EN adds out-of-range address detection and a sticky addr_err flag.
module slave_mem_port #(
  parameter int ADDRESS_WIDTH  = 15,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int LATENCY        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     module_dv,
  output logic                     mem_busy,
  output logic                     addr_err
);

  // state   | meaning
  // IDLE    | waiting for write_en / read_en
  // WR_WAIT | write accepted, counting down latency
  // RD_WAIT | read accepted, counting down latency
  // DONE    | one-cycle completion, module_dv high
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_WAIT = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;

  logic [DATA_WIDTH-1:0]     mem [2**MEM_ADDR_WIDTH];
  logic [MEM_ADDR_WIDTH-1:0] mem_idx;
  logic                      wait_done;
  logic                      mem_we;
  logic                      oor;

  assign mem_idx   = addr_q[MEM_ADDR_WIDTH-1:0];
  assign wait_done = ((state_q == WR_WAIT) || (state_q == RD_WAIT)) && (cnt_q == 4'd0);

`ifdef SLAVE_MEM_ERR_EN
  logic addr_err_q, addr_err_d;

  assign oor = (addr_q >> MEM_ADDR_WIDTH) != '0;

  always_comb begin
    addr_err_d = addr_err_q;
    if (wait_done && oor) addr_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= addr_err_d;
  end

  assign addr_err = addr_err_q;
`else
  // Upper address bits are deliberately dropped so the address wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(addr_q >> MEM_ADDR_WIDTH);
  assign oor            = 1'b0;
  assign addr_err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        // Write wins when both requests arrive together.
        if (write_en) begin
          state_d = WR_WAIT;
          cnt_d   = LAT_M1;
          addr_d  = addr;
          wdata_d = data_in;
        end else if (read_en) begin
          state_d = RD_WAIT;
          cnt_d   = LAT_M1;
          addr_d  = addr;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we = wait_done && (state_q == WR_WAIT) && !oor;

  always_comb begin
    data_out_d = data_out_q;
    if (wait_done && (state_q == RD_WAIT)) begin
      data_out_d = oor ? '1 : mem[mem_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
    end
  end

  // Array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wdata_q;
  end

  assign data_out  = data_out_q;
  assign module_dv = (state_q == DONE);
  assign mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_slave_mem_port.sv
// Randomized self-checking bench for slave_mem_port against an array-based reference model.
// Honours SLAVE_MEM_ERR_EN the same way as the design.
module tb_slave_mem_port;

  localparam int AW  = 15;
  localparam int DW  = 8;
  localparam int MAW = 12;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          module_dv;
  logic          mem_busy;
  logic          addr_err;

  slave_mem_port #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .module_dv(module_dv), .mem_busy(mem_busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] mdl [2**MAW];
  logic [DW-1:0] last_rd = '0;
  logic          err_exp = 1'b0;

`ifdef SLAVE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One request; optionally pokes a stray request in at cycle dist_c after acceptance.
  task automatic run_req(input logic we, input logic re, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int dist_c);
    int  first_dv = -1;
    int  dvs = 0;
    int  busy_bad = 0;
    bit  out_of_range;
    logic [MAW-1:0] idx;
    @(negedge clk);
    write_en = we; read_en = re; addr = a; data_in = d;
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0;
    for (int c = 0; c <= LAT + 2; c++) begin
      if (module_dv) begin
        dvs++;
        if (first_dv < 0) first_dv = c;
      end
      if (mem_busy !== (c <= LAT)) busy_bad++;
      if (c == dist_c) begin
        write_en = $urandom_range(0, 1);
        read_en  = 1'b1;
        addr     = AW'($urandom);
        data_in  = DW'($urandom);
      end else begin
        write_en = 1'b0;
        read_en  = 1'b0;
      end
      @(negedge clk);
    end
    write_en = 1'b0; read_en = 1'b0;
    if (we || re) begin
      chk("dv_latency", first_dv, LAT);
      chk("dv_count", dvs, 1);
      chk("busy_window", busy_bad, 0);
      out_of_range = (a >> MAW) != 0;
      idx = a[MAW-1:0];
      if (we) begin
        if (out_of_range && ERR_EN) err_exp = 1'b1;
        else mdl[idx] = d;
      end else begin
        last_rd = (out_of_range && ERR_EN) ? {DW{1'b1}} : mdl[idx];
      end
      chk(we ? "data_out_hold" : "read_data", data_out, last_rd);
      chk("addr_err", addr_err, err_exp);
    end
  endtask

  task automatic abort_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int rc);
    int dvs = 0;
    @(negedge clk);
    write_en = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    write_en = 1'b0;
    repeat (rc) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", mem_busy, 0);
    chk("rst_dv", module_dv, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_err", addr_err, 0);
    last_rd = '0;
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (module_dv) dvs++;
    end
    chk("abort_no_dv", dvs, 0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    rst = 1'b1;
    #12;
    chk("reset_busy", mem_busy, 0);
    chk("reset_dv", module_dv, 0);
    chk("reset_dout", data_out, 0);
    chk("reset_err", addr_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Seed a small pool of words so every later read has a known value.
    for (int i = 0; i < 32; i++) run_req(1'b1, 1'b0, AW'(i), DW'($urandom), -1);

    run_req(1'b1, 1'b0, 15'h0012, 8'hA5, -1);
    run_req(1'b0, 1'b1, 15'h0012, 8'h00, -1);
    chk("rd_0012", data_out, 8'hA5);

    run_req(1'b1, 1'b1, 15'h0003, 8'h3C, -1);
    run_req(1'b0, 1'b1, 15'h0003, 8'h00, -1);
    chk("rd_0003", data_out, 8'h3C);

    run_req(1'b1, 1'b0, 15'h0007, 8'h9E, 2);
    run_req(1'b0, 1'b1, 15'h0007, 8'h00, LAT);

    run_req(1'b1, 1'b0, 15'h0005, 8'h11, -1);
    abort_write(15'h0005, 8'h77, 1);
    run_req(1'b0, 1'b1, 15'h0005, 8'h00, -1);
    chk("rd_0005_abort", data_out, 8'h11);

    run_req(1'b1, 1'b0, 15'h1005, 8'h55, -1);
    run_req(1'b0, 1'b1, 15'h0005, 8'h00, -1);
`ifdef SLAVE_MEM_ERR_EN
    chk("rd_0005_oor", data_out, 8'h11);
    chk("err_set", addr_err, 1);
    run_req(1'b0, 1'b1, 15'h1005, 8'h00, -1);
    chk("rd_1005_ones", data_out, 8'hFF);
`else
    chk("rd_0005_wrap", data_out, 8'h55);
    chk("err_tied", addr_err, 0);
`endif

    for (int n = 0; n < 150; n++) begin
      ra = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = ra | AW'($urandom_range(1, 7) << MAW);
      run_req($urandom_range(0, 1) == 1, 1'b1, ra, DW'($urandom),
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, LAT) : -1);
    end

    abort_write(15'h0009, 8'hC3, 2);
    run_req(1'b0, 1'b1, 15'h0009, 8'h00, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
